reg_skid: RTL and testbench
===========================

# reg_skid

Registered two-entry skid buffer that sits between a valid/ready producer and consumer inside the RIFFA datapath. It breaks the combinational path on both the data/valid direction and the ready direction, so every output is driven directly from a flop. Typical placements are at the TX/RX engine boundaries and between channel FIFOs and the user interface. It sustains one word per cycle and preserves word order.

## Interface
- C_WIDTH, 32, data word width in bits (≥1).
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous, active-low reset.
- WR_DATA  in  C_WIDTH  producer data word.
- WR_DATA_VALID  in  1  producer asserts when WR_DATA is valid.
- WR_DATA_READY  out  1  block can accept a word this cycle; registered.
- RD_DATA  out  C_WIDTH  consumer data word; registered.
- RD_DATA_VALID  out  1  RD_DATA holds a valid word; registered.
- RD_DATA_READY  in  1  consumer accepts RD_DATA this cycle.
- COUNT  out  2  words held, 0..2; registered.

## Operation
- Storage consists of two registers. The main register drives RD_DATA. The skid register holds one overflow word.
- A write occurs on a rising CLK when WR_DATA_VALID=1 and WR_DATA_READY=1. WR_DATA_VALID is ignored while WR_DATA_READY=0.
- A read occurs on a rising CLK when RD_DATA_VALID=1 and RD_DATA_READY=1.
- State machine, with the encoding equal to COUNT:
  - EMPTY (0):
    - write → BUSY, main←WR_DATA.
  - BUSY (1):
    - write and no read → FULL, skid←WR_DATA.
    - write and read → BUSY, main←WR_DATA.
    - read only → EMPTY.
    - neither → hold.
  - FULL (2):
    - read → BUSY, main←skid.
    - no read → hold. No write is possible because WR_DATA_READY=0.
- Derived outputs:
  - RD_DATA_VALID = (next state ≠ EMPTY), registered.
  - WR_DATA_READY = (next state ≠ FULL), registered.
  - COUNT = next state, registered.
- RD_DATA holds its value while RD_DATA_VALID=1 and RD_DATA_READY=0. It is stable under backpressure.
- RD_DATA is don't-care while RD_DATA_VALID=0, but the implementation keeps the last value (no spurious toggling).
- No word is ever dropped or duplicated. Output order equals input order.

## Timing
- Reset (RST_N=0, asynchronous, effective immediately):
  - State=EMPTY, COUNT=0.
  - RD_DATA_VALID=0, RD_DATA=0.
  - WR_DATA_READY=0.
  - Skid register=0.
- First rising CLK with RST_N=1: WR_DATA_READY goes to 1. Writes are accepted from the following edge onward.
- Latency: a word written on edge N appears with RD_DATA_VALID=1 after edge N (visible in cycle N+1). This holds only when the block was EMPTY, or BUSY with a simultaneous read.
- Throughput: one word per cycle while RD_DATA_READY is held at 1. COUNT stays at 1 in steady state.
- Backpressure: after RD_DATA_READY falls, the block accepts at most one further word (into skid). WR_DATA_READY is 0 after that edge.
- Release: the first read in FULL moves skid to main. WR_DATA_READY returns to 1 after that same edge.
- Simultaneous read and write in BUSY keeps COUNT=1 with no bubble.
- Reset mid-operation: all contents are discarded and outputs take their reset values immediately, regardless of CLK.

## Test plan
- Reset:
  - Hold RST_N=0 for 3 cycles with random inputs → RD_DATA_VALID=0, WR_DATA_READY=0, COUNT=0, RD_DATA=0.
  - First edge after release → WR_DATA_READY=1.
- Single word:
  - Write 0xDEADBEEF with RD_DATA_READY=0 → next cycle RD_DATA=0xDEADBEEF, RD_DATA_VALID=1, COUNT=1.
  - Assert RD_DATA_READY one cycle → COUNT=0, RD_DATA_VALID=0.
- Streaming:
  - Write 1..100 back-to-back with RD_DATA_READY=1 → outputs 1..100 in order, one per cycle, one-cycle latency.
  - COUNT=1 throughout; WR_DATA_READY never drops.
- Fill under backpressure:
  - RD_DATA_READY=0, offer 0xA, 0xB, 0xC on consecutive cycles → 0xA and 0xB accepted, COUNT=2, WR_DATA_READY=0.
  - 0xC is held by the producer; RD_DATA=0xA stable.
- Drain:
  - From FULL(0xA, 0xB), raise RD_DATA_READY with 0xC still valid → reads 0xA then 0xB then 0xC.
  - WR_DATA_READY returns 1 after the first read; no loss or duplication.
- Mid-operation reset:
  - Drive RST_N=0 asynchronously between edges while FULL → outputs go to reset values immediately.
  - After release, a new word 0x5 is the first output; the old words never appear.
- Randomized valid/ready throttling (10k words) → scoreboard matches the input sequence exactly.

Source files
------------

// File: rtl/reg_skid.sv
// reg_skid: registered two-entry skid buffer between a valid/ready producer and consumer
//
// Every output is driven straight from a flop, so no combinational path runs
// from the consumer side to the producer side in either direction.
//
// Ports:
//   clk_i            rising-edge clock
//   rst_n_i          asynchronous active-low reset
//   wr_data_i        producer data word (C_WIDTH bits)
//   wr_data_valid_i  producer word is valid
//   wr_data_ready_o  buffer can accept a word this cycle (registered)
//   rd_data_o        consumer data word (registered, from the main register)
//   rd_data_valid_o  rd_data_o holds a valid word (registered)
//   rd_data_ready_i  consumer accepts rd_data_o this cycle
//   count_o          number of words held, 0..2 (registered, equals state)
module reg_skid #(
    parameter int C_WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [C_WIDTH-1:0] wr_data_i,
    input  logic               wr_data_valid_i,
    output logic               wr_data_ready_o,
    output logic [C_WIDTH-1:0] rd_data_o,
    output logic               rd_data_valid_o,
    input  logic               rd_data_ready_i,
    output logic [1:0]         count_o
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [C_WIDTH-1:0] main_q, main_d;
    logic [C_WIDTH-1:0] skid_q, skid_d;
    logic               rd_valid_q, wr_ready_q;
    logic               wr, rd;

    assign wr = wr_data_valid_i & wr_ready_q;
    assign rd = rd_valid_q & rd_data_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (wr) begin
                    state_d = BUSY;
                    main_d  = wr_data_i;
                end
            end
            BUSY: begin
                if (wr && !rd) begin
                    state_d = FULL;
                    skid_d  = wr_data_i;
                end else if (wr && rd) begin
                    main_d = wr_data_i;
                end else if (rd) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // wr_ready is low here, so only a read can move the state
                if (rd) begin
                    state_d = BUSY;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // ready/valid are registered from the next state so the handshake
    // outputs never depend combinationally on the other side's inputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            rd_valid_q <= 1'b0;
            wr_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            rd_valid_q <= (state_d != EMPTY);
            wr_ready_q <= (state_d != FULL);
        end
    end

    assign wr_data_ready_o = wr_ready_q;
    assign rd_data_o       = main_q;
    assign rd_data_valid_o = rd_valid_q;
    assign count_o         = state_q;
endmodule

// File: tb/tb_reg_skid.sv
// tb_reg_skid: scoreboard bench for reg_skid
module tb_reg_skid;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [1:0]  count;

    int vecs = 0;
    int errs = 0;
    int reads = 0;
    logic [31:0] sb[$];

    reg_skid #(.C_WIDTH(32)) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .wr_data_i(wr_data),
        .wr_data_valid_i(wr_valid),
        .wr_data_ready_o(wr_ready),
        .rd_data_o(rd_data),
        .rd_data_valid_o(rd_valid),
        .rd_data_ready_i(rd_ready),
        .count_o(count)
    );

    always #5 clk = ~clk;

    // monitor: every handshake the DUT presents is checked against the scoreboard
    always @(negedge clk) begin
        if (rst_n && rd_valid && rd_ready) begin
            vecs++;
            reads++;
            if (sb.size() == 0) begin
                errs++;
                $display("FAIL read: got %h, scoreboard empty", rd_data);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                if (rd_data !== e) begin
                    errs++;
                    $display("FAIL read: got %h expected %h", rd_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // one cycle of stimulus; the accepted word is pushed as expected output
    task automatic cyc(input logic v, input logic [31:0] d, input logic rr, output logic acc);
        @(posedge clk);
        #1;
        wr_valid = v;
        wr_data  = d;
        rd_ready = rr;
        @(negedge clk);
        acc = v && wr_ready;
        if (acc) sb.push_back(d);
    endtask

    initial begin
        logic acc;
        int n;
        // reset with random inputs
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            wr_valid = 1'($urandom);
            wr_data  = $urandom;
            rd_ready = 1'($urandom);
            @(negedge clk);
            chk("rst_valid", {31'b0, rd_valid}, 0);
            chk("rst_ready", {31'b0, wr_ready}, 0);
            chk("rst_count", {30'b0, count}, 0);
            chk("rst_data", rd_data, 0);
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", {31'b0, wr_ready}, 1);

        // single word
        cyc(1'b1, 32'hDEADBEEF, 1'b0, acc);
        chk("single_acc", {31'b0, acc}, 1);
        cyc(1'b0, 32'h0, 1'b0, acc);
        chk("single_data", rd_data, 32'hDEADBEEF);
        chk("single_valid", {31'b0, rd_valid}, 1);
        chk("single_count", {30'b0, count}, 1);
        cyc(1'b0, 32'h0, 1'b1, acc);
        cyc(1'b0, 32'h0, 1'b0, acc);
        chk("single_count0", {30'b0, count}, 0);
        chk("single_valid0", {31'b0, rd_valid}, 0);

        // streaming 1..100
        reads = 0;
        for (int i = 1; i <= 100; i++) begin
            cyc(1'b1, i, 1'b1, acc);
            if (!acc) begin
                errs++;
                $display("FAIL stream_acc: word %0d not accepted", i);
            end
            if (i > 1) begin
                chk("stream_count", {30'b0, count}, 1);
                chk("stream_data", rd_data, i - 1);
            end
        end
        cyc(1'b0, 32'h0, 1'b1, acc);
        cyc(1'b0, 32'h0, 1'b1, acc);
        chk("stream_reads", reads, 100);
        chk("stream_empty", {30'b0, count}, 0);

        // fill under backpressure
        cyc(1'b1, 32'hA, 1'b0, acc);
        chk("fill_a", {31'b0, acc}, 1);
        cyc(1'b1, 32'hB, 1'b0, acc);
        chk("fill_b", {31'b0, acc}, 1);
        cyc(1'b1, 32'hC, 1'b0, acc);
        chk("fill_c_held", {31'b0, acc}, 0);
        chk("fill_count", {30'b0, count}, 2);
        chk("fill_ready", {31'b0, wr_ready}, 0);
        chk("fill_data", rd_data, 32'hA);
        cyc(1'b1, 32'hC, 1'b0, acc);
        chk("fill_stable", rd_data, 32'hA);

        // drain with C still offered
        reads = 0;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 10) begin
            cyc(1'b1, 32'hC, 1'b1, acc);
            n++;
        end
        chk("drain_c_cycles", n, 2);
        n = 0;
        while (count != 0 && n < 10) begin
            cyc(1'b0, 32'h0, 1'b1, acc);
            n++;
        end
        chk("drain_reads", reads, 3);
        chk("drain_sb", sb.size(), 0);

        // mid-operation reset while FULL
        cyc(1'b1, 32'h11, 1'b0, acc);
        cyc(1'b1, 32'h22, 1'b0, acc);
        cyc(1'b0, 32'h0, 1'b0, acc);
        chk("mid_full", {30'b0, count}, 2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("mid_valid", {31'b0, rd_valid}, 0);
        chk("mid_ready", {31'b0, wr_ready}, 0);
        chk("mid_count", {30'b0, count}, 0);
        chk("mid_data", rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 32'h0, 1'b0, acc);
        reads = 0;
        cyc(1'b1, 32'h5, 1'b0, acc);
        chk("post_acc", {31'b0, acc}, 1);
        cyc(1'b0, 32'h0, 1'b1, acc);
        cyc(1'b0, 32'h0, 1'b0, acc);
        chk("post_reads", reads, 1);

        // randomized throttling, 10k words
        reads = 0;
        n = 0;
        for (int i = 0; i < 10000 && n < 60000; n++) begin
            cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0, acc);
            if (acc) i++;
        end
        n = 0;
        while (count != 0 && n < 10) begin
            cyc(1'b0, 32'h0, 1'b1, acc);
            n++;
        end
        chk("rand_reads", reads, 10000);
        chk("rand_sb", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
